// File: rtl/div_exec_unit_if.sv
// Issue-side and CDB-side signal bundle for the iterative divide unit.
// The master drives issue/flush/grant; the slave (the unit) drives busy and the CDB request.
interface div_exec_unit_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6
);
    logic             issue_valid;
    logic [1:0]       issue_op;
    logic [XLEN-1:0]  issue_rs1_data;
    logic [XLEN-1:0]  issue_rs2_data;
    logic [TAG_W-1:0] issue_tag;
    logic             flush;
    logic             cdb_grant;
    logic             div_exec_busy;
    logic             cdb_req;
    logic [TAG_W-1:0] cdb_tag;
    logic [XLEN-1:0]  cdb_result;

    modport master (
        output issue_valid, issue_op, issue_rs1_data, issue_rs2_data, issue_tag,
        output flush, cdb_grant,
        input  div_exec_busy, cdb_req, cdb_tag, cdb_result
    );

    modport slave (
        input  issue_valid, issue_op, issue_rs1_data, issue_rs2_data, issue_tag,
        input  flush, cdb_grant,
        output div_exec_busy, cdb_req, cdb_tag, cdb_result
    );
endinterface

// File: rtl/div_exec_unit.sv
// Iterative DIV/DIVU/REM/REMU unit: one restoring-division step per cycle,
// result held on the CDB request until granted.
module div_exec_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6
) (
    input logic             i_clk,
    input logic             i_rst,
    div_exec_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  ALL_ONES = '1;

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    state_t           state;
    logic [1:0]       op;
    logic [XLEN-1:0]  dividend;
    logic [XLEN-1:0]  divisor;
    logic [XLEN-1:0]  quo;
    logic [XLEN:0]    rem;
    logic [CNT_W-1:0] cnt;
    logic             neg_q;
    logic             neg_r;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  result;
    logic             busy;
    logic             req;

    logic             is_signed;
    logic [XLEN-1:0]  abs_a;
    logic [XLEN-1:0]  abs_b;
    logic [XLEN+1:0]  diff;
    logic [XLEN:0]    rem_sh;
    logic [XLEN-1:0]  q_fix;
    logic [XLEN-1:0]  r_fix;

    // op[0] set means unsigned; diff carries an extra sign bit for the trial subtract
    always_comb begin
        is_signed = ~op[0];
        abs_a     = (is_signed && dividend[XLEN-1]) ? -dividend : dividend;
        abs_b     = (is_signed && divisor[XLEN-1])  ? -divisor  : divisor;
        rem_sh    = {rem[XLEN-1:0], quo[XLEN-1]};
        diff      = {rem, quo[XLEN-1]} - {2'b00, divisor};
        q_fix     = neg_q ? -quo : quo;
        r_fix     = neg_r ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            op       <= '0;
            dividend <= '0;
            divisor  <= '0;
            quo      <= '0;
            rem      <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            tag      <= '0;
            result   <= '0;
            busy     <= 1'b0;
            req      <= 1'b0;
        end else if (bus.flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            req   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.issue_valid) begin
                        op       <= bus.issue_op;
                        dividend <= bus.issue_rs1_data;
                        divisor  <= bus.issue_rs2_data;
                        tag      <= bus.issue_tag;
                        busy     <= 1'b1;
                        state    <= PREP;
                    end
                end
                PREP: begin
                    neg_q <= is_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
                    neg_r <= is_signed & dividend[XLEN-1];
                    // Divide-by-zero and signed overflow bypass the iteration entirely
                    if (divisor == '0) begin
                        result <= op[1] ? dividend : ALL_ONES;
                        req    <= 1'b1;
                        state  <= DONE;
                    end else if (is_signed && dividend == MIN_INT && divisor == ALL_ONES) begin
                        result <= op[1] ? '0 : MIN_INT;
                        req    <= 1'b1;
                        state  <= DONE;
                    end else begin
                        rem     <= '0;
                        quo     <= abs_a;
                        divisor <= abs_b;
                        cnt     <= '0;
                        state   <= ITER;
                    end
                end
                ITER: begin
                    if (!diff[XLEN+1]) begin
                        rem <= diff[XLEN:0];
                        quo <= {quo[XLEN-2:0], 1'b1};
                    end else begin
                        rem <= rem_sh;
                        quo <= {quo[XLEN-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_CNT) state <= FIX;
                end
                FIX: begin
                    result <= op[1] ? r_fix : q_fix;
                    req    <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    if (bus.cdb_grant) begin
                        req   <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.div_exec_busy = busy;
    assign bus.cdb_req       = req;
    assign bus.cdb_tag       = tag;
    assign bus.cdb_result    = result;
endmodule

// File: tb/tb_div_exec_unit.sv
// Directed self-checking bench for div_exec_unit: latency, signed/unsigned
// results, special cases, grant back-pressure, flush and mid-op reset.
module tb_div_exec_unit;
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic i_clk = 1'b0;
    logic i_rst;
    int   tests = 0;
    int   fails = 0;
    int   viol  = 0;

    always #5 i_clk = ~i_clk;

    div_exec_unit_if #(.XLEN(32), .TAG_W(6)) bif ();

    div_exec_unit #(.XLEN(32), .TAG_W(6)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bif)
    );

    // Issuing into a busy unit is a protocol violation; the unit must ignore it
    always @(posedge i_clk) begin
        if (bif.issue_valid && bif.div_exec_busy) begin
            viol++;
            $display("[TB] protocol note: issue_valid while busy at %0t", $time);
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [1:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [5:0] t);
        bif.issue_valid    = 1'b1;
        bif.issue_op       = op;
        bif.issue_rs1_data = a;
        bif.issue_rs2_data = b;
        bif.issue_tag      = t;
        tick();
        bif.issue_valid    = 1'b0;
    endtask

    // Issue with grant held high; req must first appear at cycle 'lat'
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [5:0] t,
                          input logic [31:0] exp, input int lat);
        apply_stimulus(op, a, b, t);
        for (int i = 1; i < lat - 1; i++) tick();
        check_output({name, "_req_early"}, 32'(bif.cdb_req), 32'd0);
        tick();
        check_output({name, "_req"}, 32'(bif.cdb_req), 32'd1);
        check_output({name, "_tag"}, 32'(bif.cdb_tag), 32'(t));
        check_output({name, "_result"}, bif.cdb_result, exp);
        tick();
        check_output({name, "_idle"}, 32'(bif.div_exec_busy), 32'd0);
    endtask

    initial begin
        int req_seen;
        i_rst              = 1'b1;
        bif.issue_valid    = 1'b0;
        bif.issue_op       = 2'b00;
        bif.issue_rs1_data = '0;
        bif.issue_rs2_data = '0;
        bif.issue_tag      = '0;
        bif.flush          = 1'b0;
        bif.cdb_grant      = 1'b0;
        tick();
        tick();
        i_rst = 1'b0;
        check_output("rst_busy", 32'(bif.div_exec_busy), 32'd0);
        check_output("rst_req", 32'(bif.cdb_req), 32'd0);
        check_output("rst_tag", 32'(bif.cdb_tag), 32'd0);
        check_output("rst_result", bif.cdb_result, 32'd0);

        bif.cdb_grant = 1'b1;
        apply_stimulus(OP_DIVU, 32'd100, 32'd7, 6'd5);
        for (int i = 1; i < 34; i++) tick();
        check_output("divu_req_c34", 32'(bif.cdb_req), 32'd0);
        tick();
        check_output("divu_req_c35", 32'(bif.cdb_req), 32'd1);
        check_output("divu_tag", 32'(bif.cdb_tag), 32'd5);
        check_output("divu_result", bif.cdb_result, 32'd14);
        check_output("divu_busy_c35", 32'(bif.div_exec_busy), 32'd1);
        tick();
        check_output("divu_busy_c36", 32'(bif.div_exec_busy), 32'd0);
        check_output("divu_req_c36", 32'(bif.cdb_req), 32'd0);

        run_op("rem_neg", OP_REM, 32'hFFFF_FFF9, 32'd2, 6'd1, 32'hFFFF_FFFF, 35);
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 6'd2, 32'hFFFF_FFFD, 35);
        run_op("div_by0", OP_DIV, 32'h0000_1234, 32'd0, 6'd3, 32'hFFFF_FFFF, 2);
        run_op("remu_by0", OP_REMU, 32'h0000_1234, 32'd0, 6'd4, 32'h0000_1234, 2);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 6'd6, 32'h8000_0000, 2);
        run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 6'd7, 32'd0, 2);
        run_op("divu_big", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 6'd8, 32'd0, 35);
        run_op("divu_max", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 6'd10, 32'hFFFF_FFFF, 35);
        run_op("remu_max", OP_REMU, 32'hFFFF_FFFF, 32'h8000_0000, 6'd11, 32'h7FFF_FFFF, 35);
        run_op("div_negdiv", OP_DIV, 32'd100, 32'hFFFF_FFF9, 6'd63, 32'hFFFF_FFF2, 35);

        // Grant withheld for 10 cycles, with a stray issue during the wait
        bif.cdb_grant = 1'b0;
        apply_stimulus(OP_DIVU, 32'd1000, 32'd10, 6'd9);
        for (int i = 1; i < 35; i++) tick();
        check_output("hold_req", 32'(bif.cdb_req), 32'd1);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                bif.issue_valid    = 1'b1;
                bif.issue_op       = OP_DIVU;
                bif.issue_rs1_data = 32'd5;
                bif.issue_rs2_data = 32'd1;
                bif.issue_tag      = 6'd1;
            end
            tick();
            bif.issue_valid = 1'b0;
            check_output("hold_tag", 32'(bif.cdb_tag), 32'd9);
            check_output("hold_result", bif.cdb_result, 32'd100);
            check_output("hold_busy", 32'(bif.div_exec_busy), 32'd1);
        end
        bif.cdb_grant = 1'b1;
        tick();
        check_output("hold_release_busy", 32'(bif.div_exec_busy), 32'd0);
        check_output("hold_release_req", 32'(bif.cdb_req), 32'd0);
        tick();
        check_output("hold_no_stray", 32'(bif.div_exec_busy), 32'd0);
        check_output("viol_count", 32'(viol), 32'd1);

        // Flush mid-iteration, then a fresh op the following cycle
        apply_stimulus(OP_DIVU, 32'h0000_FFFF, 32'd3, 6'd2);
        for (int i = 1; i < 20; i++) tick();
        bif.flush = 1'b1;
        tick();
        bif.flush = 1'b0;
        check_output("flush_busy", 32'(bif.div_exec_busy), 32'd0);
        check_output("flush_req", 32'(bif.cdb_req), 32'd0);
        apply_stimulus(OP_DIVU, 32'd9, 32'd3, 6'd3);
        req_seen = 0;
        for (int i = 1; i < 34; i++) begin
            tick();
            if (bif.cdb_req) req_seen++;
        end
        check_output("flush_no_req", 32'(req_seen), 32'd0);
        tick();
        check_output("after_flush_req", 32'(bif.cdb_req), 32'd1);
        check_output("after_flush_tag", 32'(bif.cdb_tag), 32'd3);
        check_output("after_flush_result", bif.cdb_result, 32'd3);
        tick();

        // Flush wins over a simultaneous issue
        bif.flush = 1'b1;
        apply_stimulus(OP_DIVU, 32'd8, 32'd2, 6'd4);
        bif.flush = 1'b0;
        check_output("flush_vs_issue", 32'(bif.div_exec_busy), 32'd0);

        // Flush coincident with grant: broadcast stands, unit returns to idle
        bif.cdb_grant = 1'b0;
        apply_stimulus(OP_DIV, 32'd7, 32'd0, 6'd12);
        tick();
        check_output("fg_req", 32'(bif.cdb_req), 32'd1);
        check_output("fg_result", bif.cdb_result, 32'hFFFF_FFFF);
        bif.cdb_grant = 1'b1;
        bif.flush     = 1'b1;
        tick();
        bif.flush = 1'b0;
        check_output("fg_idle", 32'(bif.div_exec_busy), 32'd0);
        check_output("fg_req_low", 32'(bif.cdb_req), 32'd0);

        // Synchronous reset mid-operation, then normal ops afterwards
        apply_stimulus(OP_DIVU, 32'd50, 32'd5, 6'd7);
        for (int i = 1; i < 10; i++) tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check_output("mid_rst_busy", 32'(bif.div_exec_busy), 32'd0);
        check_output("mid_rst_req", 32'(bif.cdb_req), 32'd0);
        check_output("mid_rst_tag", 32'(bif.cdb_tag), 32'd0);
        check_output("mid_rst_result", bif.cdb_result, 32'd0);
        run_op("post_rst_div", OP_DIV, 32'hFFFF_FF9C, 32'd7, 6'd12, 32'hFFFF_FFF2, 35);
        run_op("post_rst_rem", OP_REM, 32'hFFFF_FF9C, 32'd7, 6'd13, 32'hFFFF_FFFE, 35);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/div_exec_unit.md
Name: div_exec_unit

Overview:
- Iterative 32-bit integer divide execution unit, sitting downstream of the issue unit's div issue grant.
- Accepts one issued DIV/DIVU/REM/REMU op with its operands and destination tag, and computes with a 1-bit-per-cycle restoring divider.
- Holds the result and requests the common data bus until the issue unit grants it.
- Drives div_exec_busy back to the issue unit so that no new div op is granted while an op is in flight.

Parameters:
- XLEN, 32, operand/result width.
- TAG_W, 6, ROB/RS tag width (matches cdb_tag).

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- issue_valid  in  1  issue unit grants a div op this cycle.
- issue_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- issue_rs1_data  in  XLEN  dividend.
- issue_rs2_data  in  XLEN  divisor.
- issue_tag  in  TAG_W  destination tag.
- flush  in  1  branch mispredict; discard in-flight op.
- cdb_grant  in  1  issue unit/CDB arbiter accepts this unit's result this cycle.
- div_exec_busy  out  1  unit not IDLE.
- cdb_req  out  1  result valid, requesting CDB.
- cdb_tag  out  TAG_W  tag of held result.
- cdb_result  out  XLEN  quotient or remainder.

Behaviour:
- Clock and reset: one clock (i_clk); reset is synchronous and active-high (i_rst).
- Reset values:
  - All outputs 0; state IDLE; counter 0; internal registers 0.
  - Reset mid-operation abandons the op with no CDB request.
- States: IDLE, PREP, ITER, FIX, DONE. div_exec_busy = (state != IDLE), registered.
- IDLE:
  - On issue_valid, latch op, operands and tag, then go to PREP.
  - issue_valid while busy is a protocol violation: ignored, with a bench assertion.
- PREP (1 cycle):
  - Signed ops (DIV, REM): take absolute values; record neg_q = sign(rs1) xor sign(rs2) and neg_r = sign(rs1).
  - Divisor zero: quotient = all ones, remainder = rs1; go to DONE.
  - Signed overflow (rs1 = 0x80000000, rs2 = 0xFFFFFFFF, op DIV/REM): quotient = 0x80000000, remainder = 0; go to DONE.
  - Otherwise clear the 33-bit partial remainder, load the dividend into the quotient shift register, counter = 0, go to ITER.
- ITER (exactly XLEN cycles):
  - Each cycle, shift {rem, quo} left by 1 and trial-subtract the divisor.
  - If the result is non-negative, keep it and set quo[0] = 1; otherwise restore.
  - Counter increments each cycle; after count XLEN-1, go to FIX.
- FIX (1 cycle):
  - Apply neg_q to the quotient and neg_r to the remainder (two's complement) for signed ops.
  - Select quotient (DIV/DIVU) or remainder (REM/REMU) into cdb_result; go to DONE.
- DONE:
  - cdb_req = 1; cdb_tag and cdb_result are held stable until cdb_grant.
  - The grant cycle is the broadcast cycle; next state is IDLE with cdb_req = 0.
  - Earliest next issue is the cycle after IDLE is reached.
- Latency, counting from the issue_valid cycle as cycle 0:
  - Normal op: PREP at 1, ITER 2..33, FIX 34, cdb_req first high in cycle 35.
  - Special case: cdb_req high in cycle 2.
  - Grant wait adds cycles one-for-one.
- flush:
  - In any state, next state is IDLE, cdb_req = 0, busy = 0.
  - flush has priority over issue_valid in the same cycle (the op is not accepted).
  - flush coincident with cdb_grant: the broadcast of the already-registered result stands; the unit still goes to IDLE.
- Arithmetic:
  - Partial remainder is XLEN+1 bits wide.
  - Result negation is modulo 2^XLEN.
  - DIVU/REMU never negate.

Test Plan:
- DIVU 100/7, tag 5, cdb_grant tied 1 -> cdb_req rises exactly at cycle 35; tag 5, result 14; busy falls the next cycle.
- REM rs1 = 0xFFFFFFF9 (-7), rs2 = 2; DIV same operands -> REM returns 0xFFFFFFFF (-1); DIV returns 0xFFFFFFFD (-3).
- DIV x/0 with rs1 = 0x1234 -> cdb_req at cycle 2 with 0xFFFFFFFF; REMU x/0 returns 0x1234. DIV 0x80000000 / -1 -> 0x80000000 at cycle 2.
- cdb_grant withheld 10 cycles after cdb_req -> tag and result stable throughout, busy stays high; issue_valid during the wait is ignored (assertion fires).
- flush at cycle 20 of ITER -> idle next cycle, no cdb_req ever; a new DIVU 9/3 issued the following cycle returns 3 at its own cycle 35.
- i_rst at cycle 10, then a new op -> all outputs 0 the cycle after reset; the new op completes normally with correct latency.
